// File: rtl/ct_f_spsram_taint_scrub_pkg.sv
// Shared types and helpers for the single-port SRAM model with taint shadow and scrub engine.
// Optional taint tracking is enabled by defining CT_SPSRAM_TAINT_EN.
package ct_spsram_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } scrub_state_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Taint carried by the address/control path of an access.
  function automatic logic ctl_taint(input logic addr_t_any, input logic cen_t, input logic gwen_t);
    return addr_t_any | cen_t | gwen_t;
  endfunction

endpackage

// File: rtl/ct_f_spsram_taint_scrub_if.sv
// Bus bundle for the single-port SRAM model: active-low access controls, data and taint lanes.
// Taint lanes are always present; they are only consumed when CT_SPSRAM_TAINT_EN is defined.
interface ct_f_spsram_taint_scrub_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 144
);
  logic [ADDR_WIDTH-1:0] A;
  logic [ADDR_WIDTH-1:0] A_t0;
  logic                  CEN;
  logic                  CEN_t0;
  logic                  GWEN;
  logic                  GWEN_t0;
  logic [DATA_WIDTH-1:0] WEN;
  logic [DATA_WIDTH-1:0] WEN_t0;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] D_t0;
  logic [DATA_WIDTH-1:0] Q;
  logic [DATA_WIDTH-1:0] Q_t0;
  logic                  SCRUB_REQ;
  logic                  SCRUB_BUSY;
  logic                  ADDR_TAINT_ERR;

  modport master (
    output A, A_t0, CEN, CEN_t0, GWEN, GWEN_t0, WEN, WEN_t0, D, D_t0, SCRUB_REQ,
    input  Q, Q_t0, SCRUB_BUSY, ADDR_TAINT_ERR
  );

  modport slave (
    input  A, A_t0, CEN, CEN_t0, GWEN, GWEN_t0, WEN, WEN_t0, D, D_t0, SCRUB_REQ,
    output Q, Q_t0, SCRUB_BUSY, ADDR_TAINT_ERR
  );

endinterface

// File: rtl/ct_spsram_scrub_ctrl.sv
// Scrub FSM and counter; muxes either the zero-fill sweep or the external access onto the array port.
module ct_spsram_scrub_ctrl
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 144,
  parameter int SCRUB_ON_RESET = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_scrub_req,
  input  logic                  i_cen,
  input  logic                  i_gwen,
  input  logic [DATA_WIDTH-1:0] i_wen,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic                  o_busy,
  output logic                  o_scrub,
  output logic                  o_acc,
  output logic                  o_wr,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_a,
  output logic [DATA_WIDTH-1:0] o_mem_wmask,
  output logic [DATA_WIDTH-1:0] o_mem_d
);

  scrub_state_e          r_state;
  scrub_state_e          w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= (SCRUB_ON_RESET != 0) ? SCRUB : READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // DEPTH is a power of two, so the last entry is the all-ones count.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      SCRUB: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_next = READY;
        end
      end
      READY: begin
        if (i_scrub_req) begin
          w_state_next = SCRUB;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  // Nothing touches the arrays while reset is held.
  always_comb begin
    o_busy      = (r_state == SCRUB);
    o_scrub     = 1'b0;
    o_acc       = 1'b0;
    o_wr        = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_a     = i_a;
    o_mem_wmask = ~i_wen;
    o_mem_d     = i_d;
    if (i_rst_n) begin
      if (r_state == SCRUB) begin
        o_scrub     = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_a     = r_cnt;
        o_mem_wmask = '1;
        o_mem_d     = '0;
      end else if (!i_cen) begin
        o_acc    = 1'b1;
        o_wr     = !i_gwen;
        o_mem_we = !i_gwen;
      end
    end
  end

endmodule

// File: rtl/ct_f_spsram_taint_scrub.sv
// Single-port SRAM model with write-first output latch, scrub engine and optional per-bit taint shadow.
// Define CT_SPSRAM_TAINT_EN to build the shadow array, taint propagation and ADDR_TAINT_ERR.
module ct_f_spsram_taint_scrub
  import ct_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 144,
  parameter int SCRUB_ON_RESET = 1
) (
  input logic                      CLK,
  input logic                      CPURST_B,
  ct_f_spsram_taint_scrub_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic                  w_busy;
  logic                  w_scrub;
  logic                  w_acc;
  logic                  w_wr;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_a;
  logic [DATA_WIDTH-1:0] w_mem_wmask;
  logic [DATA_WIDTH-1:0] w_mem_d;
  logic [DATA_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0] w_q_t0;
  logic                  w_err;

  ct_spsram_scrub_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .SCRUB_ON_RESET (SCRUB_ON_RESET)
  ) u_scrub_ctrl (
    .i_clk       (CLK),
    .i_rst_n     (CPURST_B),
    .i_scrub_req (bus.SCRUB_REQ),
    .i_cen       (bus.CEN),
    .i_gwen      (bus.GWEN),
    .i_wen       (bus.WEN),
    .i_a         (bus.A),
    .i_d         (bus.D),
    .o_busy      (w_busy),
    .o_scrub     (w_scrub),
    .o_acc       (w_acc),
    .o_wr        (w_wr),
    .o_mem_we    (w_mem_we),
    .o_mem_a     (w_mem_a),
    .o_mem_wmask (w_mem_wmask),
    .o_mem_d     (w_mem_d)
  );

  // One column per data bit keeps the per-bit write mask a plain write enable.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
    logic r_mem [DEPTH];
    logic r_q;

    always_ff @(posedge CLK) begin
      if (w_mem_we && w_mem_wmask[gi]) begin
        r_mem[w_mem_a] <= w_mem_d[gi];
      end
    end

    // Write-first: a written bit returns the new data, an unwritten bit the stored one.
    always_ff @(posedge CLK) begin
      if (!CPURST_B) begin
        r_q <= 1'b0;
      end else if (w_acc) begin
        r_q <= (w_wr && w_mem_wmask[gi]) ? bus.D[gi] : r_mem[w_mem_a];
      end
    end

    assign w_q[gi] = r_q;
  end

`ifdef CT_SPSRAM_TAINT_EN
  logic w_ctl_t;
  logic r_err;

  assign w_ctl_t = ctl_taint(|bus.A_t0, bus.CEN_t0, bus.GWEN_t0);

  always_ff @(posedge CLK) begin
    if (!CPURST_B) begin
      r_err <= 1'b0;
    end else if (w_wr && w_ctl_t) begin
      r_err <= 1'b1;
    end
  end

  assign w_err = r_err;

  // Unmasked bits still accumulate control/WEN taint: a tainted write may have hit any bit.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shadow
    logic r_shd [DEPTH];
    logic r_q_t0;
    logic w_old;
    logic w_new;

    assign w_old = r_shd[w_mem_a];
    assign w_new = w_mem_wmask[gi] ? (bus.D_t0[gi] | bus.WEN_t0[gi] | w_ctl_t)
                                   : (w_old | bus.WEN_t0[gi] | w_ctl_t);

    always_ff @(posedge CLK) begin
      if (w_mem_we) begin
        r_shd[w_mem_a] <= w_scrub ? 1'b0 : w_new;
      end
    end

    always_ff @(posedge CLK) begin
      if (!CPURST_B) begin
        r_q_t0 <= 1'b0;
      end else if (w_acc) begin
        r_q_t0 <= w_wr ? w_new : (w_old | w_ctl_t);
      end
    end

    assign w_q_t0[gi] = r_q_t0;
  end
`else
  logic w_unused_t0;

  assign w_unused_t0 = ^{bus.A_t0, bus.CEN_t0, bus.GWEN_t0, bus.WEN_t0, bus.D_t0, w_scrub};
  assign w_q_t0      = '0;
  assign w_err       = 1'b0;
`endif

  assign bus.Q              = w_q;
  assign bus.Q_t0           = w_q_t0;
  assign bus.SCRUB_BUSY     = w_busy;
  assign bus.ADDR_TAINT_ERR = w_err;

endmodule

// File: tb/tb_ct_f_spsram_taint_scrub.sv
// Directed bench for the SRAM model: reset/scrub timing, table of read/write vectors, scrub and reset corners.
module tb_ct_f_spsram_taint_scrub;
  localparam int AW = 4;
  localparam int DW = 8;
`ifdef CT_SPSRAM_TAINT_EN
  localparam bit TAINT = 1'b1;
`else
  localparam bit TAINT = 1'b0;
`endif

  logic CLK = 1'b0;
  logic CPURST_B = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 CLK = ~CLK;

  ct_f_spsram_taint_scrub_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_f_spsram_taint_scrub #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .SCRUB_ON_RESET (1)
  ) dut (
    .CLK      (CLK),
    .CPURST_B (CPURST_B),
    .bus      (bus)
  );

  typedef struct packed {
    logic          cen;
    logic          gwen;
    logic [AW-1:0] a;
    logic [AW-1:0] a_t0;
    logic          cen_t0;
    logic          gwen_t0;
    logic [DW-1:0] wen;
    logic [DW-1:0] wen_t0;
    logic [DW-1:0] d;
    logic [DW-1:0] d_t0;
    logic [DW-1:0] q;
    logic [DW-1:0] qt;
    logic          err;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic cen, input logic gwen, input logic [AW-1:0] a,
                              input logic [AW-1:0] a_t0, input logic cen_t0, input logic gwen_t0,
                              input logic [DW-1:0] wen, input logic [DW-1:0] wen_t0,
                              input logic [DW-1:0] d, input logic [DW-1:0] d_t0,
                              input logic [DW-1:0] q, input logic [DW-1:0] qt, input logic err);
    vec_t v;
    v.cen = cen; v.gwen = gwen; v.a = a; v.a_t0 = a_t0; v.cen_t0 = cen_t0; v.gwen_t0 = gwen_t0;
    v.wen = wen; v.wen_t0 = wen_t0; v.d = d; v.d_t0 = d_t0;
    v.q = q; v.qt = TAINT ? qt : '0; v.err = TAINT ? err : 1'b0;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.CEN = v.cen; bus.GWEN = v.gwen; bus.A = v.a; bus.A_t0 = v.a_t0;
    bus.CEN_t0 = v.cen_t0; bus.GWEN_t0 = v.gwen_t0; bus.WEN = v.wen; bus.WEN_t0 = v.wen_t0;
    bus.D = v.d; bus.D_t0 = v.d_t0;
  endtask

  task automatic idle();
    drive(mk(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, '1, '0, '0, '0, '0, '0, 1'b0));
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Counts cycles with SCRUB_BUSY high starting at the current negedge, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.SCRUB_BUSY === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    // cen gwen a a_t0 cen_t0 gwen_t0 wen wen_t0 d d_t0 -> q qt err
    vecs[0]  = mk(0, 0, 4'h3, 4'h0, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h0F, 8'hA5, 8'h0F, 0);
    vecs[1]  = mk(0, 1, 4'h3, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h0F, 0);
    vecs[2]  = mk(1, 1, 4'h5, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h0F, 0);
    vecs[3]  = mk(1, 1, 4'h5, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h0F, 0);
    vecs[4]  = mk(1, 0, 4'h5, 4'h0, 0, 0, 8'h00, 8'h00, 8'h66, 8'h00, 8'hA5, 8'h0F, 0);
    vecs[5]  = mk(0, 0, 4'h3, 4'h0, 0, 0, 8'hF0, 8'h80, 8'hFF, 8'h0F, 8'hAF, 8'h8F, 0);
    vecs[6]  = mk(0, 1, 4'h3, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hAF, 8'h8F, 0);
    vecs[7]  = mk(0, 1, 4'h3, 4'h0, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hAF, 8'hFF, 0);
    vecs[8]  = mk(0, 1, 4'h5, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    vecs[9]  = mk(0, 0, 4'h7, 4'h1, 0, 0, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h3C, 8'hFF, 1);
    vecs[10] = mk(0, 1, 4'h9, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    vecs[11] = mk(0, 1, 4'h7, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hFF, 1);
    vecs[12] = mk(0, 0, 4'h3, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hAF, 8'h8F, 1);
    vecs[13] = mk(0, 1, 4'h3, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hAF, 8'h8F, 1);

    idle();
    bus.SCRUB_REQ = 1'b0;
    CPURST_B = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_q", 0, bus.Q, 0);
    check("rst_qt", 0, bus.Q_t0, 0);
    check("rst_err", 0, bus.ADDR_TAINT_ERR, 0);
    check("rst_busy", 0, bus.SCRUB_BUSY, 1);
    CPURST_B = 1'b1;
    count_busy(n);
    check("init_busy_len", 0, n, 16);
    $display("init scrub: busy cycles %0d", n);

    for (int a = 0; a < 16; a++) begin
      drive(mk(0, 1, 4'(a), 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
      step();
      check("init_rd_q", a, bus.Q, 0);
      check("init_rd_qt", a, bus.Q_t0, 0);
      $display("init read A=%0h Q=%h Q_t0=%h", a, bus.Q, bus.Q_t0);
    end

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      step();
      check("vec_q", i, bus.Q, vecs[i].q);
      check("vec_qt", i, bus.Q_t0, vecs[i].qt);
      check("vec_err", i, bus.ADDR_TAINT_ERR, vecs[i].err);
      check("vec_busy", i, bus.SCRUB_BUSY, 0);
      $display("vec %0d: CEN=%b GWEN=%b A=%h Q=%h Q_t0=%h ERR=%b", i, vecs[i].cen, vecs[i].gwen,
               vecs[i].a, bus.Q, bus.Q_t0, bus.ADDR_TAINT_ERR);
    end

    // Requested scrub with reads to a non-zero entry issued throughout, and a repeated request mid-scrub.
    idle();
    bus.SCRUB_REQ = 1'b1;
    step();
    bus.SCRUB_REQ = 1'b0;
    drive(mk(0, 1, 4'h7, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    n = 0;
    while (bus.SCRUB_BUSY === 1'b1 && n < 40) begin
      n++;
      check("scrub_hold_q", n, bus.Q, 8'hAF);
      bus.SCRUB_REQ = (n == 5);
      step();
    end
    bus.SCRUB_REQ = 1'b0;
    check("req_busy_len", 0, n, 16);
    $display("requested scrub: busy cycles %0d", n);
    drive(mk(0, 1, 4'h3, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    step();
    check("post_scrub_q3", 0, bus.Q, 0);
    check("post_scrub_qt3", 0, bus.Q_t0, 0);
    $display("post scrub read A=3 Q=%h Q_t0=%h", bus.Q, bus.Q_t0);

    // Reset at scrub count 7 restarts a full sweep.
    drive(mk(0, 0, 4'h2, 4'h0, 0, 0, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 8'h00, 0));
    step();
    check("pre_rst_wr_q", 0, bus.Q, 8'h77);
    idle();
    bus.SCRUB_REQ = 1'b1;
    step();
    bus.SCRUB_REQ = 1'b0;
    repeat (7) step();
    check("mid_scrub_busy", 0, bus.SCRUB_BUSY, 1);
    check("mid_scrub_hold_q", 0, bus.Q, 8'h77);
    CPURST_B = 1'b0;
    step();
    check("midrst_q", 0, bus.Q, 0);
    check("midrst_qt", 0, bus.Q_t0, 0);
    check("midrst_err", 0, bus.ADDR_TAINT_ERR, 0);
    check("midrst_busy", 0, bus.SCRUB_BUSY, 1);
    CPURST_B = 1'b1;
    count_busy(n);
    check("midrst_busy_len", 0, n, 16);
    $display("scrub after mid-scrub reset: busy cycles %0d", n);
    drive(mk(0, 1, 4'h2, 4'h0, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0));
    step();
    check("final_rd_q2", 0, bus.Q, 0);
    $display("final read A=2 Q=%h Q_t0=%h", bus.Q, bus.Q_t0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
